ins_mem_loader: RTL and testbench
=================================

INS_MEM_LOADER -- requirements
Module: ins_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning log2 of instruction-memory depth in 32-bit words (64 words).
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port RST  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a program load.
REQ-005 SHALL have port word_count  input  ADDR_W+1  number of words to load; sampled only on accepted start.
REQ-006 SHALL have port in_valid  input  1  byte-stream valid.
REQ-007 SHALL have port in_data  input  8  byte-stream data, most-significant byte of each word first.
REQ-008 SHALL have port in_ready  output  1  loader can accept a byte this cycle.
REQ-009 SHALL have port InsMemRW  output  1  instruction-memory write strobe, 1 = write, 0 = read.
REQ-010 SHALL have port InstructionIn  output  32  word written to instruction memory.
REQ-011 SHALL have port imAddr  output  32  byte address of the write, word index x 4.
REQ-012 SHALL have port cpuRST  output  1  active-high reset held on the CPU core during load.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port done  output  1  load complete, CPU released.

Function
REQ-015 SHALL implement FSM states IDLE, RECV, WRITE, DONE.
REQ-016 IDLE: start=1 -> RECV with word index 0, byte count 0, word_count latched; if latched count is 0 -> DONE directly, no writes.
REQ-017 Latched word_count greater than 2^ADDR_W SHALL be clamped to 2^ADDR_W.
REQ-018 in_ready SHALL be 1 only in RECV; a byte is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-019 Accepted bytes SHALL shift into a 32-bit assembly register from the left: first byte lands in bits 31:24 after four bytes.
REQ-020 Acceptance of the 4th byte SHALL move the FSM to WRITE on that edge; in_ready SHALL be 0 during WRITE.
REQ-021 In WRITE, for exactly one cycle: InsMemRW=1, InstructionIn = assembled word, imAddr = word index x 4 (upper bits zero).
REQ-022 Leaving WRITE: word index increments; if new index equals latched count -> DONE, else -> RECV with byte count 0.
REQ-023 InsMemRW SHALL be 0 in all states other than WRITE; InstructionIn and imAddr hold last written values outside WRITE.
REQ-024 in_valid=0 in RECV SHALL stall with no state change; no timeout.
REQ-025 busy SHALL be 1 in RECV and WRITE, 0 otherwise.
REQ-026 cpuRST SHALL be 1 in IDLE, RECV, WRITE and 0 in DONE; done SHALL be 1 only in DONE.
REQ-027 start while busy SHALL be ignored.
REQ-028 start in DONE SHALL re-enter RECV (cpuRST returns to 1 the next cycle, done to 0) with same rules as REQ-016.
REQ-029 Word index SHALL never wrap: maximum index written is 2^ADDR_W - 1.

Reset
REQ-030 RST=0 SHALL, asynchronously, force IDLE, word index 0, byte count 0, assembly register 0, InstructionIn=0, imAddr=0, InsMemRW=0, in_ready=0, busy=0, done=0, cpuRST=1.
REQ-031 RST asserted mid-load SHALL abandon the load immediately; no partial word is written; after release the FSM waits for a fresh start.

Verification
REQ-032 start, word_count=2, bytes 20,01,00,05,AC,02,00,04 streamed with in_valid=1 -> WRITE pulses: addr 0x0 data 0x20010005, addr 0x4 data 0xAC020004; done=1, cpuRST=0 one cycle after second pulse.
REQ-033 Same load with in_valid low every other cycle -> identical writes, each InsMemRW pulse exactly one cycle, in_ready=0 during WRITE.
REQ-034 start, word_count=0 -> DONE next cycle, zero InsMemRW pulses, cpuRST=0.
REQ-035 word_count=100 with ADDR_W=6 -> exactly 64 writes, last at imAddr 0xFC, then DONE.
REQ-036 RST=0 after 2 bytes of word 1 -> all outputs at reset values same cycle; later start loads word 0 at imAddr 0 from new bytes.
REQ-037 start pulsed during RECV -> ignored, load completes with original count; start in DONE -> cpuRST=1, new load proceeds.

Source files
------------

// File: rtl/ins_mem_loader.sv
// rtl/ins_mem_loader.sv - byte-stream program loader that writes 32-bit words into instruction memory
// Holds the CPU in reset while the image is streamed in, then releases it.
module ins_mem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              InsMemRW,
  output logic [31:0]       InstructionIn,
  output logic [31:0]       imAddr,
  output logic              cpuRST,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] IDX_ZERO = '0;
  localparam logic [ADDR_W:0] IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_idx;
  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_asm;
  logic [31:0]       r_instr;
  logic [31:0]       r_addr;

  logic              w_start_ok;
  logic [ADDR_W:0]   w_count_clamped;
  logic              w_accept;
  logic              w_last_byte;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_idx_next;
  logic [31:0]       w_word_addr;

  // A new load is only taken when no load is running.
  assign w_start_ok      = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_count_clamped = (word_count > DEPTH) ? DEPTH : word_count;
  assign w_accept        = in_valid && (r_state == RECV);
  assign w_last_byte     = w_accept && (r_byte_cnt == 2'd3);
  assign w_word          = {r_asm[23:0], in_data};
  assign w_idx_next      = r_idx + IDX_ONE;
  assign w_word_addr     = {{(30 - ADDR_W){1'b0}}, r_idx[ADDR_W-1:0], 2'b00};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next_state = (w_count_clamped == IDX_ZERO) ? DONE : RECV;
        end
      end
      RECV: begin
        if (w_last_byte) begin
          w_next_state = WRITE;
        end
      end
      WRITE: begin
        w_next_state = (w_idx_next == r_count) ? DONE : RECV;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count    <= '0;
      r_idx      <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_instr    <= '0;
      r_addr     <= '0;
    end else begin
      if (w_start_ok) begin
        r_count    <= w_count_clamped;
        r_idx      <= '0;
        r_byte_cnt <= '0;
      end
      if (w_accept) begin
        r_asm      <= w_word;
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      // Write-port registers are loaded as the FSM enters WRITE and then hold.
      if (w_last_byte) begin
        r_instr <= w_word;
        r_addr  <= w_word_addr;
      end
      if (r_state == WRITE) begin
        r_idx      <= w_idx_next;
        r_byte_cnt <= '0;
      end
    end
  end

  assign in_ready      = (r_state == RECV);
  assign InsMemRW      = (r_state == WRITE);
  assign busy          = (r_state == RECV) || (r_state == WRITE);
  assign done          = (r_state == DONE);
  assign cpuRST        = (r_state != DONE);
  assign InstructionIn = r_instr;
  assign imAddr        = r_addr;

endmodule

// File: tb/tb_ins_mem_loader.sv
// tb/tb_ins_mem_loader.sv - scoreboard bench for ins_mem_loader
module tb_ins_mem_loader;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [6:0]  word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        InsMemRW;
  logic [31:0] InstructionIn;
  logic [31:0] imAddr;
  logic        cpuRST;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int n_writes = 0;
  logic prev_rw = 1'b0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];

  ins_mem_loader #(.ADDR_W(6)) dut (
    .CLK(CLK), .RST(RST), .start(start), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .InsMemRW(InsMemRW), .InstructionIn(InstructionIn), .imAddr(imAddr),
    .cpuRST(cpuRST), .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse is matched against the scoreboard queue.
  always @(negedge CLK) begin
    if (RST && InsMemRW) begin
      n_writes++;
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%h:%h expected=none", imAddr, InstructionIn);
      end else begin
        chk("write_addr", imAddr, exp_a.pop_front());
        chk("write_data", InstructionIn, exp_d.pop_front());
      end
      chk("in_ready_during_write", {31'd0, in_ready}, 32'd0);
      chk("write_pulse_width", {31'd0, prev_rw}, 32'd0);
    end
    prev_rw <= InsMemRW;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input logic [6:0] wc);
    start = 1'b1;
    word_count = wc;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_word(input logic [31:0] a, input logic [31:0] d);
    exp_a.push_back(a);
    exp_d.push_back(d);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit gap);
    int t;
    t = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 expected=1");
      in_valid = 1'b0;
      return;
    end
    tick();
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    push_byte(w[31:24], gap);
    push_byte(w[23:16], gap);
    push_byte(w[15:8], gap);
    push_byte(w[7:0], gap);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_InsMemRW"}, {31'd0, InsMemRW}, 32'd0);
    chk({tag, "_InstructionIn"}, InstructionIn, 32'd0);
    chk({tag, "_imAddr"}, imAddr, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_cpuRST"}, {31'd0, cpuRST}, 32'd1);
  endtask

  initial begin
    int w0;
    logic [31:0] w;

    RST = 1'b0;
    start = 1'b0;
    word_count = '0;
    in_valid = 1'b0;
    in_data = '0;
    #3;
    chk_reset_outputs("reset");
    #9;
    RST = 1'b1;
    tick();

    // Two-word load, continuous stream.
    do_start(7'd2);
    chk("start_busy", {31'd0, busy}, 32'd1);
    expect_word(32'h0, 32'h20010005);
    expect_word(32'h4, 32'hAC020004);
    send_word(32'h20010005, 1'b0);
    send_word(32'hAC020004, 1'b0);
    in_valid = 1'b0;
    chk("last_write_cycle", {31'd0, InsMemRW}, 32'd1);
    tick();
    chk("load1_done", {31'd0, done}, 32'd1);
    chk("load1_cpuRST", {31'd0, cpuRST}, 32'd0);
    chk("load1_busy", {31'd0, busy}, 32'd0);
    chk("load1_queue_empty", exp_a.size(), 32'd0);

    // Same load with a bubble after every byte, restarted from DONE.
    do_start(7'd2);
    chk("restart_cpuRST", {31'd0, cpuRST}, 32'd1);
    chk("restart_done", {31'd0, done}, 32'd0);
    expect_word(32'h0, 32'h20010005);
    expect_word(32'h4, 32'hAC020004);
    send_word(32'h20010005, 1'b1);
    send_word(32'hAC020004, 1'b1);
    chk("load2_done", {31'd0, done}, 32'd1);
    chk("load2_hold_addr", imAddr, 32'h4);
    chk("load2_hold_data", InstructionIn, 32'hAC020004);
    chk("load2_queue_empty", exp_a.size(), 32'd0);

    // Zero-length load from IDLE.
    RST = 1'b0;
    #2;
    RST = 1'b1;
    tick();
    w0 = n_writes;
    do_start(7'd0);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_cpuRST", {31'd0, cpuRST}, 32'd0);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    chk("zero_no_writes", n_writes - w0, 32'd0);

    // Oversized count clamps to the 64-word memory.
    w0 = n_writes;
    do_start(7'd100);
    for (int i = 0; i < 64; i++) begin
      w = {i[7:0], i[7:0] ^ 8'hA5, 8'h3C, ~i[7:0]};
      expect_word(i * 4, w);
      send_word(w, 1'b0);
    end
    in_valid = 1'b0;
    tick();
    chk("clamp_write_count", n_writes - w0, 32'd64);
    chk("clamp_last_addr", imAddr, 32'hFC);
    chk("clamp_done", {31'd0, done}, 32'd1);
    chk("clamp_queue_empty", exp_a.size(), 32'd0);

    // Reset in the middle of word 1 abandons the load.
    do_start(7'd2);
    expect_word(32'h0, 32'h11223344);
    send_word(32'h11223344, 1'b0);
    push_byte(8'h55, 1'b0);
    push_byte(8'h66, 1'b0);
    in_valid = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    chk_reset_outputs("midload_reset");
    chk("midload_queue_empty", exp_a.size(), 32'd0);
    #2;
    RST = 1'b1;
    tick();
    tick();
    chk("after_reset_idle_busy", {31'd0, busy}, 32'd0);
    do_start(7'd1);
    expect_word(32'h0, 32'hDEADBEEF);
    send_word(32'hDEADBEEF, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("reload_done", {31'd0, done}, 32'd1);
    chk("reload_queue_empty", exp_a.size(), 32'd0);

    // Start pulsed mid-load must be ignored.
    do_start(7'd2);
    expect_word(32'h0, 32'hCAFEF00D);
    expect_word(32'h4, 32'h0BADC0DE);
    push_byte(8'hCA, 1'b0);
    push_byte(8'hFE, 1'b0);
    in_valid = 1'b0;
    do_start(7'd1);
    chk("ignored_start_busy", {31'd0, busy}, 32'd1);
    push_byte(8'hF0, 1'b0);
    push_byte(8'h0D, 1'b0);
    send_word(32'h0BADC0DE, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("ignored_start_done", {31'd0, done}, 32'd1);
    chk("ignored_start_queue_empty", exp_a.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
